// File: rtl/saph_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// saph_fpu_arbiter
// Shares one FPU between N_REQ requesters. A round-robin grant is made every
// cycle the FPU is ready and the tag FIFO has room. The granted requester ID is
// pushed into an in-order tag FIFO. Each returning FPU result is steered back
// to the requester whose tag sits at the FIFO head. The arbiter adds no latency
// in either direction.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_req_trig        per-requester request valid
//   i_req_lhs/rhs     per-requester operands, packed 32 bits per requester
//   i_req_mode        per-requester FPU mode, packed 2 bits per requester
//   o_req_ready       one-hot grant (request accepted this cycle)
//   o_res_trig        one-hot result-valid pulse
//   o_res_val         shared result bus, zero when no result returns
//   o_has_modes       passthrough of the FPU's supported-mode mask
//   o_err_orphan      sticky: FPU returned a result with no tag outstanding
//   o_fpu_d_*         request side toward the FPU
//   i_fpu_d_ready     FPU can accept a request
//   i_fpu_q_trig/res  FPU result return
//   i_fpu_has_modes   FPU supported-mode mask
// -----------------------------------------------------------------------------
module saph_fpu_arbiter #(
  parameter int N_REQ     = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     i_req_trig,
  input  logic [N_REQ*32-1:0]  i_req_lhs,
  input  logic [N_REQ*32-1:0]  i_req_rhs,
  input  logic [N_REQ*2-1:0]   i_req_mode,
  output logic [N_REQ-1:0]     o_req_ready,
  output logic [N_REQ-1:0]     o_res_trig,
  output logic [31:0]          o_res_val,
  output logic [3:0]           o_has_modes,
  output logic                 o_err_orphan,
  output logic                 o_fpu_d_trig,
  output logic [31:0]          o_fpu_d_lhs,
  output logic [31:0]          o_fpu_d_rhs,
  output logic [1:0]           o_fpu_d_mode,
  input  logic                 i_fpu_d_ready,
  input  logic                 i_fpu_q_trig,
  input  logic [31:0]          i_fpu_q_res,
  input  logic [3:0]           i_fpu_has_modes
);

  localparam int IW = $clog2(N_REQ);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] r_rr_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] r_tag_mem [TAG_DEPTH];
  logic          r_err_orphan;

  logic          w_can_issue;
  logic          w_grant_vld;
  logic [IW-1:0] w_grant_id;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;
  logic          w_pop;
  logic [IW-1:0] w_head;

  // Round-robin search starting at r_rr_ptr. Held off during reset so no
  // grant leaks out combinationally while state is being cleared. A full FIFO
  // blocks issue even if a result pops this cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned; that is what keeps this block from inferring latches.
    w_can_issue = !rst && i_fpu_d_ready && (r_count < CW'(TAG_DEPTH));
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N_REQ)) w_sum = w_sum - (IW+1)'(N_REQ);
      w_idx = w_sum[IW-1:0];
      if (w_can_issue && !w_grant_vld && i_req_trig[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_idx;
      end
    end
  end

  // Grant fan-out and operand mux; the FPU sees zeros when nothing issues.
  always_comb begin
    o_req_ready  = '0;
    o_fpu_d_trig = w_grant_vld;
    o_fpu_d_lhs  = '0;
    o_fpu_d_rhs  = '0;
    o_fpu_d_mode = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_vld && (w_grant_id == IW'(i))) begin
        o_req_ready[i] = 1'b1;
        o_fpu_d_lhs    = i_req_lhs[i*32 +: 32];
        o_fpu_d_rhs    = i_req_rhs[i*32 +: 32];
        o_fpu_d_mode   = i_req_mode[i*2 +: 2];
      end
    end
  end

  // Result steering: the head tag names the requester that owns this result.
  assign w_pop  = !rst && i_fpu_q_trig && (r_count != '0);
  assign w_head = r_tag_mem[r_rd_ptr];

  always_comb begin
    o_res_trig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pop && (w_head == IW'(i))) o_res_trig[i] = 1'b1;
    end
  end

  assign o_res_val    = (!rst && i_fpu_q_trig) ? i_fpu_q_res : 32'd0;
  assign o_has_modes  = i_fpu_has_modes;
  assign o_err_orphan = r_err_orphan;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_grant_vld) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_rr_ptr <= (w_grant_id == IW'(N_REQ-1)) ? '0 : w_grant_id + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_grant_vld, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_fpu_q_trig && (r_count == '0)) r_err_orphan <= 1'b1;
    end
  end

  // NOTE: the tag storage has no reset; entries are only read behind the
  // count, which is reset, so clearing them would add reset fan-out for nothing.
  always_ff @(posedge clk) begin
    if (w_grant_vld) r_tag_mem[r_wr_ptr] <= w_grant_id;
  end

endmodule

// File: tb/tb_saph_fpu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_saph_fpu_arbiter
// Drives four requesters into saph_fpu_arbiter, with a 3-cycle behavioural FPU
// that can stall its results or emit an unsolicited one. A cycle-level
// reference model (request list, round-robin pointer, outstanding-tag queue)
// predicts every output.
// -----------------------------------------------------------------------------
module tb_saph_fpu_arbiter;

  localparam int N   = 4;
  localparam int TD  = 8;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_trig;
  logic [N*32-1:0] req_lhs, req_rhs;
  logic [N*2-1:0]  req_mode;
  logic [N-1:0]    req_ready, res_trig;
  logic [31:0]     res_val;
  logic [3:0]      has_modes;
  logic            err_orphan;
  logic            d_trig;
  logic [31:0]     d_lhs, d_rhs;
  logic [1:0]      d_mode;
  logic            d_ready;
  logic            q_trig;
  logic [31:0]     q_res;
  logic [3:0]      fpu_modes;

  always #5 clk = ~clk;

  saph_fpu_arbiter #(.N_REQ(N), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .i_req_trig(req_trig), .i_req_lhs(req_lhs), .i_req_rhs(req_rhs),
    .i_req_mode(req_mode),
    .o_req_ready(req_ready), .o_res_trig(res_trig), .o_res_val(res_val),
    .o_has_modes(has_modes), .o_err_orphan(err_orphan),
    .o_fpu_d_trig(d_trig), .o_fpu_d_lhs(d_lhs), .o_fpu_d_rhs(d_rhs),
    .o_fpu_d_mode(d_mode),
    .i_fpu_d_ready(d_ready), .i_fpu_q_trig(q_trig), .i_fpu_q_res(q_res),
    .i_fpu_has_modes(fpu_modes)
  );

  function automatic logic [31:0] fpu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] m);
    return (a + b) ^ {30'd0, m};
  endfunction

  // ---------------- behavioural FPU ----------------
  typedef struct { logic [31:0] res; int due; } fq_t;
  fq_t fq[$];
  int  cyc;
  logic hold, rel1, inj;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      cyc    <= 0;
      q_trig <= 1'b0;
      q_res  <= 32'd0;
    end else begin
      cyc <= cyc + 1;
      if (d_trig && d_ready) fq.push_back('{res: fpu_f(d_lhs, d_rhs, d_mode), due: cyc + LAT});
      if (inj) begin
        q_trig <= 1'b1;
        q_res  <= 32'hDEAD_0001;
      end else if ((!hold || rel1) && fq.size() > 0 && fq[0].due <= cyc + 1) begin
        q_trig <= 1'b1;
        q_res  <= fq[0].res;
        void'(fq.pop_front());
      end else begin
        q_trig <= 1'b0;
        q_res  <= $urandom;
      end
    end
  end

  // ---------------- requesters and reference model ----------------
  typedef struct { int id; logic [31:0] val; } tag_t;
  tag_t        m_tags[$];
  int          m_rr;
  logic        m_err;
  logic [31:0] lhs[N], rhs[N];
  logic [1:0]  mode[N];
  logic [N-1:0] mask;
  int          g_last;
  int          n_grants;
  logic [N-1:0] obs_ready;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int g;
    logic [31:0] exp_rt, exp_rv;
    logic orphan;
    g         = -1;
    obs_ready = req_ready;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_d_trig", 32'(d_trig), 32'd0);
      chk("rst_res_trig", 32'(res_trig), 32'd0);
      chk("rst_err_orphan", 32'(err_orphan), 32'd0);
      m_tags.delete();
      m_rr   = 0;
      m_err  = 1'b0;
      g_last = -1;
      return;
    end
    if (d_ready && m_tags.size() < TD) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (g < 0 && req_trig[i]) g = i;
      end
    end
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("d_trig", 32'(d_trig), (g >= 0) ? 32'd1 : 32'd0);
    chk("d_lhs", d_lhs, (g >= 0) ? lhs[g] : 32'd0);
    chk("d_rhs", d_rhs, (g >= 0) ? rhs[g] : 32'd0);
    chk("d_mode", 32'(d_mode), (g >= 0) ? 32'(mode[g]) : 32'd0);
    orphan = 1'b0;
    exp_rt = 32'd0;
    exp_rv = 32'd0;
    if (q_trig && m_tags.size() > 0) begin
      exp_rt = 32'd1 << m_tags[0].id;
      exp_rv = m_tags[0].val;
    end else if (q_trig) begin
      orphan = 1'b1;
    end
    chk("res_trig", 32'(res_trig), exp_rt);
    if (!orphan) chk("res_val", res_val, exp_rv);
    chk("err_orphan", 32'(err_orphan), 32'(m_err));
    if (q_trig) begin
      if (m_tags.size() > 0) void'(m_tags.pop_front());
      else m_err = 1'b1;
    end
    if (g >= 0) begin
      m_tags.push_back('{id: g, val: fpu_f(lhs[g], rhs[g], mode[g])});
      m_rr = (g + 1) % N;
      n_grants++;
    end
    g_last = g;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      if (g_last == i) begin
        lhs[i]  = $urandom;
        rhs[i]  = $urandom;
        mode[i] = 2'($urandom);
      end
      req_lhs[i*32 +: 32] = lhs[i];
      req_rhs[i*32 +: 32] = rhs[i];
      req_mode[i*2 +: 2]  = mode[i];
    end
    req_trig = mask;
    g_last   = -1;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic drain();
    int n;
    mask = '0;
    hold = 1'b0;
    rel1 = 1'b0;
    d_ready = 1'b1;
    n = 0;
    while ((m_tags.size() > 0 || fq.size() > 0) && n < 60) begin
      step();
      n++;
    end
    chk("drain_done", 32'(m_tags.size() + fq.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; d_ready = 1'b1; hold = 1'b0; rel1 = 1'b0; inj = 1'b0;
    mask = '1; fpu_modes = 4'b1011; m_rr = 0; m_err = 1'b0; g_last = -1;
    for (int i = 0; i < N; i++) begin
      lhs[i] = $urandom; rhs[i] = $urandom; mode[i] = 2'($urandom);
    end
    apply();

    // 1: reset with all requests asserted, then first grant to requester 0
    repeat (3) step();
    chk("has_modes", 32'(has_modes), 32'hB);
    rst = 1'b0;
    step();
    chk("first_grant", 32'(obs_ready), 32'd1);

    // 2: full throughput, all requesters, results 3 cycles later
    repeat (20) step();
    drain();

    // 3: lone requester 2, then 0 and 2 alternate
    mask = 4'b0100;
    repeat (6) step();
    mask = 4'b0101;
    repeat (8) step();
    drain();

    // 4: FPU stalls results; 8 grants fill the FIFO, one pop frees one slot
    mask = '1; hold = 1'b1; n_grants = 0;
    repeat (14) step();
    chk("full_grants", 32'(n_grants), 32'd8);
    n_grants = 0;
    rel1 = 1'b1;
    step();
    rel1 = 1'b0;
    repeat (4) step();
    chk("one_more_grant", 32'(n_grants), 32'd1);
    drain();

    // 5: FPU not ready while requests pend; pointer must not move
    mask = 4'b1010;
    step();
    d_ready = 1'b0;
    repeat (4) step();
    d_ready = 1'b1;
    repeat (6) step();
    drain();

    // 6: orphan result, then reset with three tags in flight
    inj = 1'b1;
    step();
    inj = 1'b0;
    repeat (3) step();
    chk("orphan_sticky", 32'(err_orphan), 32'd1);
    mask = '1;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    mask = '0;
    repeat (8) step();
    chk("orphan_cleared", 32'(err_orphan), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (n % 8 == 0) mask = 4'($urandom);
      d_ready = ($urandom_range(0, 3) != 0);
      hold    = ($urandom_range(0, 7) == 0);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
